uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: clock cycles per serial bit; legal range 1..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wdata  input  8  byte to transmit; sampled when wen=1.
REQ-006 wen  input  1  write strobe, one byte per cycle high; writes into transmit FIFO.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH bytes; writes ignored while high.
REQ-008 drop  output  1  one-cycle pulse: a write was rejected because full=1.
REQ-009 txd  output  1  serial line, registered, idle high.
REQ-010 busy  output  1  high while a frame is in progress or the FIFO is non-empty.

Function
REQ-011 Frame SHALL be: start bit 0, data bits d0..d7 LSB first, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-012 FSM states: IDLE, START, DATA, STOP.
REQ-013 IDLE->START on the edge where IDLE and FIFO non-empty; the head byte SHALL be popped into a shift register on that same edge; txd=0 after it.
REQ-014 START->DATA after CLKS_PER_BIT cycles; txd=d0.
REQ-015 DATA: bit counter 0..7 advances every CLKS_PER_BIT cycles; txd=d[bit]; after bit 7 completes, DATA->STOP, txd=1.
REQ-016 STOP: after CLKS_PER_BIT cycles -> START, popping the next byte, if FIFO non-empty (back-to-back, no idle gap); otherwise -> IDLE.
REQ-017 Baud counter SHALL be wide enough for CLKS_PER_BIT-1 and restart at 0 on every bit boundary; with CLKS_PER_BIT=1 each state bit lasts one cycle.
REQ-018 Latency: wen high at edge E into an empty FIFO with FSM in IDLE -> txd falls after edge E+1 (no bypass path).
REQ-019 FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
REQ-020 full=1 iff occupancy==FIFO_DEPTH; full and occupancy are registered values from before the edge.
REQ-021 wen while full=1 SHALL be dropped, even if a pop occurs on the same edge; FIFO contents unchanged; drop=1 for the following cycle.
REQ-022 wen while not full, on the same edge as a pop: both occur, occupancy unchanged.
REQ-023 The byte being shifted SHALL NOT be affected by wdata or wen after it is popped.
REQ-024 busy = (state!=IDLE) or (occupancy!=0), registered or combinational from registers; no glitches from inputs.

Reset
REQ-025 While reset=1: state=IDLE, txd=1, full=0, drop=0, busy=0, occupancy=0, pointers=0, counters=0, shift register=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) with txd=1; FIFO contents discarded; no partial frame resumes after release.
REQ-027 First edge after reset release behaves as IDLE with empty FIFO; wen on that edge is accepted.

Verification
REQ-028 CLKS_PER_BIT=1, write 0xA5 once -> txd from edge E+1: 0,1,0,1,0,0,1,0,1,1 then idle 1; busy high for exactly 11 cycles from edge E.
REQ-029 CLKS_PER_BIT=4, write 0x01 -> start low 4 cycles, d0 high 4 cycles, d1..d7 low 28 cycles, stop high 4 cycles; 40-cycle frame.
REQ-030 CLKS_PER_BIT=1, FIFO_DEPTH=4, write 0x11,0x22,0x33,0x44,0x55,0x66 on consecutive cycles -> first pops after edge 2; 0x55 accepted, 0x66 rejected with drop pulse; frames 0x11..0x55 back-to-back with no idle cycle between stop and next start.
REQ-031 Fill FIFO to full during a frame, then write on the pop edge -> write dropped, drop=1, occupancy returns to FIFO_DEPTH-1.
REQ-032 Assert reset during bit d3 of 0xFF with 2 bytes queued -> txd=1 immediately, busy=0, no further frames after release until a new write.
REQ-033 Write 0x3C, toggle wdata randomly during transmission -> serial output still 0x3C.

Source files
------------

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte-write / serial-line bundle between a UART transmitter and its user
//
// Signals:
//   wdata [7:0]  byte to transmit, sampled on an edge where wen=1
//   wen          write strobe, at most one byte per cycle
//   full         transmit FIFO holds FIFO_DEPTH bytes; writes are ignored while high
//   drop         one-cycle pulse after a write was rejected because full was high
//   txd          serial line, registered, idles high
//   busy         a frame is on the line or bytes are still queued
//
// Modports:
//   master  the byte producer (drives wdata/wen, observes the rest)
//   slave   the transmitter itself

interface uart_tx_if;
    logic [7:0] wdata;
    logic       wen;
    logic       full;
    logic       drop;
    logic       txd;
    logic       busy;

    modport master (
        output wdata,
        output wen,
        input  full,
        input  drop,
        input  txd,
        input  busy
    );

    modport slave (
        input  wdata,
        input  wen,
        output full,
        output drop,
        output txd,
        output busy
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter fed by a small circular transmit FIFO
//
// Parameters:
//   CLKS_PER_BIT  clock cycles each serial bit is held (1..65535)
//   FIFO_DEPTH    transmit FIFO entries, power of two in 2..16
//
// Ports:
//   clk    single clock, all state changes on its rising edge
//   reset  asynchronous active-high reset; aborts any frame and empties the FIFO
//   bus    uart_tx_if.slave: wdata/wen in, full/drop/txd/busy out
//
// Frame on txd: start bit 0, d0..d7 LSB first, stop bit 1, each bit CLKS_PER_BIT
// cycles. Queued bytes go out back-to-back: the stop bit's last cycle is followed
// directly by the next start bit.

module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Serialiser state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;

    // Transmit FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   occ_q;
    logic             drop_q;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic bit_done;

    // full comes from the registered occupancy, so a write on an edge where the
    // FIFO was full is refused even if the serialiser pops on that same edge.
    assign fifo_full  = (occ_q == OCC_FULL);
    assign fifo_empty = (occ_q == '0);
    assign push       = bus.wen && !fifo_full;

    // Last cycle of the current serial bit.
    assign bit_done = (baud_q == BAUD_LAST);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                txd_d  = 1'b1;
                // Head byte moves into the shift register on the same edge
                // the start bit begins; later wdata activity cannot touch it.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end

            START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // Shift right so the bit on the line is always shift_q[0];
                        // the bit that follows it is presented from shift_q[1].
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    baud_d = '0;
                    bit_d  = '0;
                    // Chain straight into the next frame when bytes are waiting,
                    // so no idle cycle separates stop from the next start.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // FIFO pointers, occupancy and the drop pulse. Pointers wrap naturally
    // because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= bus.wen && fifo_full;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the pointers say
    // they were written after the last reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.full = fifo_full;
    assign bus.drop = drop_q;
    assign bus.txd  = txd_q;
    assign bus.busy = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx (CLKS_PER_BIT 1 and 4)

module tb_uart_tx;

    localparam int DEPTH  = 4;
    localparam int CPB4   = 4;
    localparam int FRAME1 = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_if bus1 ();
    uart_tx_if bus4 ();

    uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB4), .FIFO_DEPTH(DEPTH)) dut4 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus4)
    );

    // ---------------- reference model (CLKS_PER_BIT = 1 instance) ----------------
    int         cyc        = 0;
    int         next_free  = 0;
    logic [7:0] pending[$];
    logic [7:0] exp_byte  [4096];
    int         exp_start [4096];
    int         exp_wr     = 0;
    logic       exp_full   = 1'b0;
    logic       exp_busy   = 1'b0;
    logic       exp_drop   = 1'b0;
    logic       full_before;

    // A frame occupies FRAME1 edges; a queued byte starts on the first edge
    // where the line is free and it was already in the queue before that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending.delete();
            next_free = 0;
            exp_full  = 1'b0;
            exp_busy  = 1'b0;
            exp_drop  = 1'b0;
        end else begin
            cyc++;
            full_before = (pending.size() == DEPTH);
            if (pending.size() > 0 && cyc >= next_free) begin
                exp_byte[exp_wr]  = pending.pop_front();
                exp_start[exp_wr] = cyc;
                exp_wr++;
                next_free = cyc + FRAME1;
            end
            exp_drop = bus1.wen && full_before;
            if (bus1.wen && !full_before) begin
                pending.push_back(bus1.wdata);
            end
            exp_full = (pending.size() == DEPTH);
            exp_busy = (cyc < next_free) || (pending.size() != 0);
        end
    end

    // Expected serial waveform: bit k of a frame spans samples k*cpb..k*cpb+cpb-1.
    function automatic logic [63:0] frame_bits(input logic [7:0] b, input int cpb);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 10 * cpb; i++) begin
            int k;
            k = i / cpb;
            if (k == 0)      v[i] = 1'b0;
            else if (k == 9) v[i] = 1'b1;
            else             v[i] = b[k-1];
        end
        return v;
    endfunction

    // ---------------- directed expectations for the CLKS_PER_BIT = 4 instance ----------------
    logic [7:0] exp4_byte  [16];
    int         exp4_start [16];
    int         wr4 = 0;

    // ---------------- monitor / checker ----------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          exp_rd = 0;
    int          rd4    = 0;
    bit          rx_active  = 1'b0;
    int          rx_idx     = 0;
    logic [7:0]  rx_exp;
    logic [63:0] rx_bits;
    bit          rx4_active = 1'b0;
    int          rx4_idx    = 0;
    logic [7:0]  rx4_exp;
    logic [63:0] rx4_bits;
    bit          end_req  = 1'b0;
    bit          end_done = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_txd1",  64'(bus1.txd),  64'd1);
            check("rst_busy1", 64'(bus1.busy), 64'd0);
            check("rst_full1", 64'(bus1.full), 64'd0);
            check("rst_drop1", 64'(bus1.drop), 64'd0);
            check("rst_txd4",  64'(bus4.txd),  64'd1);
            rx_active  = 1'b0;
            rx4_active = 1'b0;
            exp_rd     = exp_wr;
            rd4        = wr4;
        end else begin
            check("full", 64'(bus1.full), 64'(exp_full));
            check("drop", 64'(bus1.drop), 64'(exp_drop));
            check("busy", 64'(bus1.busy), 64'(exp_busy));

            if (!rx_active && bus1.txd === 1'b0) begin
                if (exp_rd == exp_wr) begin
                    check("unexpected_start1", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    rx_active = 1'b1;
                    rx_idx    = 0;
                    rx_bits   = '0;
                    rx_exp    = exp_byte[exp_rd];
                    check("start_cycle1", 64'(cyc), 64'(exp_start[exp_rd]));
                    exp_rd++;
                end
            end
            if (rx_active) begin
                rx_bits[rx_idx] = bus1.txd;
                rx_idx++;
                if (rx_idx == FRAME1) begin
                    check("frame1", rx_bits, frame_bits(rx_exp, 1));
                    rx_active = 1'b0;
                end
            end

            if (!rx4_active && bus4.txd === 1'b0) begin
                if (rd4 == wr4) begin
                    check("unexpected_start4", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    rx4_active = 1'b1;
                    rx4_idx    = 0;
                    rx4_bits   = '0;
                    rx4_exp    = exp4_byte[rd4];
                    check("start_cycle4", 64'(cyc), 64'(exp4_start[rd4]));
                    rd4++;
                end
            end
            if (rx4_active) begin
                rx4_bits[rx4_idx] = bus4.txd;
                rx4_idx++;
                if (rx4_idx == 10 * CPB4) begin
                    check("frame4", rx4_bits, frame_bits(rx4_exp, CPB4));
                    rx4_active = 1'b0;
                end
            end

            if (end_req && !end_done) begin
                check("frames_unseen1", 64'(exp_wr - exp_rd), 64'd0);
                check("frames_unseen4", 64'(wr4 - rd4), 64'd0);
                check("rx_open1", 64'(rx_active), 64'd0);
                check("rx_open4", 64'(rx4_active), 64'd0);
                check("idle_busy4", 64'(bus4.busy), 64'd0);
                end_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic [7:0] b);
        bus1.wen   = 1'b1;
        bus1.wdata = b;
        @(posedge clk);
        #1;
        bus1.wen = 1'b0;
    endtask

    task automatic write4(input logic [7:0] b);
        // Written at edge cyc+1 into an idle instance; start bit begins after cyc+2.
        exp4_byte[wr4]  = b;
        exp4_start[wr4] = cyc + 2;
        wr4++;
        bus4.wen   = 1'b1;
        bus4.wdata = b;
        @(posedge clk);
        #1;
        bus4.wen = 1'b0;
    endtask

    initial begin
        bus1.wen   = 1'b0;
        bus1.wdata = '0;
        bus4.wen   = 1'b0;
        bus4.wdata = '0;
        repeat (3) @(posedge clk);
        #1;

        // Write on the very first edge after reset release: 0xA5 single frame.
        rst = 1'b0;
        write1(8'hA5);
        idle(14);

        // Six consecutive writes into a depth-4 FIFO: 0x66 must be dropped.
        for (int i = 1; i <= 6; i++) begin
            bus1.wen   = 1'b1;
            bus1.wdata = 8'(i * 8'h11);
            idle(1);
        end
        bus1.wen = 1'b0;
        idle(60);

        // Keep the FIFO full across pop edges so writes land on pop edges too.
        bus1.wen = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus1.wdata = 8'($urandom);
            idle(1);
        end
        bus1.wen = 1'b0;
        idle(60);

        // Reset during d3 of 0xFF with two more bytes queued.
        write1(8'hFF);
        write1(8'h01);
        write1(8'h02);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(30);

        // wdata wiggles while 0x3C is on the line.
        write1(8'h3C);
        for (int i = 0; i < 12; i++) begin
            bus1.wdata = 8'($urandom);
            idle(1);
        end
        idle(5);

        // Random traffic: heavy (drops) then light (gaps between frames).
        for (int i = 0; i < 400; i++) begin
            bus1.wen   = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
            bus1.wdata = 8'($urandom);
            idle(1);
        end
        bus1.wen = 1'b0;
        idle(80);

        // CLKS_PER_BIT = 4 instance: 0x01 then a random byte.
        write4(8'h01);
        idle(45);
        write4(8'($urandom));
        idle(45);

        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_done; i++) begin
            @(posedge clk);
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
